// File: rtl/dmem_responder.sv
// Backing data-memory responder: single outstanding request, programmable wait states.
// Optional byte-strobe stores are enabled by defining DMEM_BYTE_STROBE_EN.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3,
  parameter int ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rerr_q, rerr_d;
  logic [31:0]        mem_q [DEPTH];

  logic               req_err;
  logic               commit;
  logic               c_write;
  logic [IDX_W-1:0]   c_idx;
  logic [31:0]        c_wdata;
  logic               c_err;
  logic [3:0]         c_wstrb;
  logic               mem_we;

  // Range check on the full address so high bits never alias into the array.
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   (req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));

  // With zero wait states the commit happens on the accept edge, straight from the inputs.
  assign c_write = (LATENCY == 0) ? req_write : wr_q;
  assign c_idx   = (LATENCY == 0) ? req_addr[IDX_W+1:2] : idx_q;
  assign c_wdata = (LATENCY == 0) ? req_wdata : wdata_q;
  assign c_err   = (LATENCY == 0) ? req_err : err_q;

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0] wstrb_q, wstrb_d;
  assign c_wstrb = (LATENCY == 0) ? req_wstrb : wstrb_q;
  assign wstrb_d = (state_q == S_IDLE && req_valid) ? req_wstrb : wstrb_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) wstrb_q <= 4'h0;
    else          wstrb_q <= wstrb_d;
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^req_wstrb;
  assign c_wstrb      = 4'hF;
`endif

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    rerr_d     = rerr_q;
    commit     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_addr[IDX_W+1:2];
          wdata_d = req_wdata;
          err_d   = req_err;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          rerr_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (commit) begin
      rerr_d  = c_err;
      rdata_d = (!c_err && !c_write) ? mem_q[c_idx] : 32'h0;
    end
  end

  assign mem_we = commit && c_write && !c_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage is deliberately not reset; contents survive reset_n.
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && c_wstrb[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 with LATENCY=3, instance 1 with LATENCY=0.
// Expected store results follow DMEM_BYTE_STROBE_EN when it is defined.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_rdata[2];
  logic        resp_err  [2];
  logic        busy      [2];

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [2][16];

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH(256), .LATENCY(3), .ADDR_W(32)) u_dut_l3 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0])
  );

  dmem_responder #(.DEPTH(256), .LATENCY(0), .ADDR_W(32)) u_dut_l0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1])
  );

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
`ifdef DMEM_BYTE_STROBE_EN
    for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = d[8*i +: 8];
`else
    r = d;
`endif
    return r;
  endfunction

  // One full transaction; resp_ready stays low for 'hold' cycles of RESP.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] st, input int hold,
                     output logic [31:0] rd, output logic e, output int lat);
    int n;
    @(negedge clock);
    req_valid[s] = 1'b1; req_write[s] = w; req_addr[s] = a;
    req_wdata[s] = d; req_wstrb[s] = st; resp_ready[s] = 1'b0;
    n = 0;
    while (!req_ready[s] && n < 50) begin @(negedge clock); n++; end
    chk("req_ready_before_accept", req_ready[s], 1'b1);
    @(posedge clock); #1;
    req_valid[s] = 1'b0;
    lat = 1;
    while (!resp_valid[s] && lat < 60) begin @(posedge clock); #1; lat++; end
    rd = resp_rdata[s];
    e  = resp_err[s];
    repeat (hold) begin @(posedge clock); #1; end
    resp_ready[s] = 1'b1;
    @(posedge clock); #1;
    resp_ready[s] = 1'b0;
    chk("resp_valid_after_handshake", resp_valid[s], 1'b0);
  endtask

  // Transaction checked against the behavioural memory model.
  task automatic run_model(input int s, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] st, input int hold);
    logic [31:0] rd, exp_rd;
    logic        e;
    bit          exp_err;
    int          lat;
    exp_err = (a % 4 != 0) || (a / 4 >= 256);
    exp_rd  = 32'h0;
    if (!exp_err && !w) exp_rd = mdl[s][a / 4];
    txn(s, w, a, d, st, hold, rd, e, lat);
    if (!exp_err && w) mdl[s][a / 4] = merge(mdl[s][a / 4], d, st);
    chk($sformatf("rnd%0d_rdata@%h", s, a), rd, exp_rd);
    chk($sformatf("rnd%0d_err@%h", s, a), e, exp_err);
    chk($sformatf("rnd%0d_latency", s), lat, (s == 0 ? 3 : 0) + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[14];
    logic [31:0] rd, exp_bs;
    logic        e;
    int          lat, n;

    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0013, 32'h0, 32'h0, 1'b1};
    tbl[3]  = '{1'b0, 32'h0000_0400, 32'h0, 32'h0, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_0000, 32'h0102_0304, 32'h0, 1'b0};
    tbl[6]  = '{1'b1, 32'h0000_0400, 32'h5555_5555, 32'h0, 1'b1};
    tbl[7]  = '{1'b0, 32'h0000_0000, 32'h0, 32'h0102_0304, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_03FC, 32'h0, 32'h0BAD_F00D, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0008, 32'hAAAA_AAAA, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_0008, 32'h0, 32'hAAAA_AAAA, 1'b0};
    tbl[12] = '{1'b1, 32'h0000_03FE, 32'h1234_5678, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1};

    for (int s = 0; s < 2; s++) begin
      req_valid[s] = 1'b0; req_write[s] = 1'b0; req_addr[s] = 32'h0;
      req_wdata[s] = 32'h0; req_wstrb[s] = 4'hF; resp_ready[s] = 1'b0;
    end
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset%0d_flags", s),
          {req_ready[s], resp_valid[s], resp_err[s], busy[s]}, 4'b1000);
      chk($sformatf("reset%0d_rdata", s), resp_rdata[s], 32'h0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].d, 4'hF, i % 3, rd, e, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
      chk($sformatf("vec%0d_latency", i), lat, 4);
    end

    // Backpressure: response held, pending store to 0x20 blocked until after handshake.
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h10; resp_ready[0] = 1'b0;
    chk("bp_ready_idle", req_ready[0], 1'b1);
    @(posedge clock); #1;
    req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'hCAFE_F00D; req_wstrb[0] = 4'hF;
    n = 1;
    while (!resp_valid[0] && n < 60) begin @(posedge clock); #1; n++; end
    chk("bp_latency", n, 4);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_hold%0d_flags", k), {resp_valid[0], req_ready[0], resp_err[0]}, 3'b100);
      chk($sformatf("bp_hold%0d_rdata", k), resp_rdata[0], 32'hDEAD_BEEF);
      @(posedge clock); #1;
    end
    resp_ready[0] = 1'b1;
    @(posedge clock); #1;
    chk("bp_after_hs_flags", {resp_valid[0], req_ready[0], busy[0]}, 3'b010);
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    chk("bp_accept_next_cycle", busy[0], 1'b1);
    n = 1;
    while (!resp_valid[0] && n < 60) begin @(posedge clock); #1; n++; end
    chk("bp_store_resp", {resp_valid[0], resp_err[0]}, 2'b10);
    chk("bp_store_rdata", resp_rdata[0], 32'h0);
    @(posedge clock); #1;
    resp_ready[0] = 1'b0;
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, e, lat);
    chk("bp_load20", rd, 32'hCAFE_F00D);

    // Reset while the store to 0x8 is still waiting: it must never commit.
    @(negedge clock);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h8;
    req_wdata[0] = 32'h1234_5678; req_wstrb[0] = 4'hF; resp_ready[0] = 1'b1;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    chk("rst_wait_busy", busy[0], 1'b1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_wait_flags", {req_ready[0], resp_valid[0], resp_err[0], busy[0]}, 4'b1000);
    chk("rst_wait_rdata", resp_rdata[0], 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    resp_ready[0] = 1'b0;
    txn(0, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd, e, lat);
    chk("rst_wait_load8", rd, 32'hAAAA_AAAA);

    // Byte strobes over 0xAAAAAAAA, then an all-zero strobe.
    txn(0, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0, rd, e, lat);
    chk("strb_store_err", e, 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd, e, lat);
`ifdef DMEM_BYTE_STROBE_EN
    exp_bs = 32'hAA22_AA44;
`else
    exp_bs = 32'h1122_3344;
`endif
    chk("strb_load8", rd, exp_bs);
    txn(0, 1'b1, 32'h8, 32'h0, 4'h0, 1, rd, e, lat);
    chk("strb0_store_err", e, 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'hF, 0, rd, e, lat);
`ifdef DMEM_BYTE_STROBE_EN
    exp_bs = 32'hAA22_AA44;
`else
    exp_bs = 32'h0;
`endif
    chk("strb0_load8", rd, exp_bs);

    // LATENCY=0 back-to-back loads with resp_ready held high.
    txn(1, 1'b1, 32'h0, 32'h0000_1111, 4'hF, 0, rd, e, lat);
    chk("l0_store_latency", lat, 1);
    txn(1, 1'b1, 32'h4, 32'h0000_2222, 4'hF, 0, rd, e, lat);
    @(negedge clock);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0; resp_ready[1] = 1'b1;
    @(posedge clock); #1;
    chk("l0_first_resp", {resp_valid[1], req_ready[1]}, 2'b10);
    chk("l0_first_rdata", resp_rdata[1], 32'h0000_1111);
    req_addr[1] = 32'h4;
    @(posedge clock); #1;
    chk("l0_gap_cycle", {resp_valid[1], req_ready[1]}, 2'b01);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    chk("l0_second_resp", resp_valid[1], 1'b1);
    chk("l0_second_rdata", resp_rdata[1], 32'h0000_2222);
    @(posedge clock); #1;
    resp_ready[1] = 1'b0;
    chk("l0_second_done", resp_valid[1], 1'b0);

    // Randomized traffic against the model on both latencies.
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        mdl[s][i] = 32'h0;
        run_model(s, 1'b1, 32'(i * 4), $urandom, 4'hF, 0);
      end
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        int          kind;
        kind = $urandom_range(0, 7);
        a = 32'($urandom_range(0, 15) * 4);
        if (kind == 0) a = a + 32'($urandom_range(1, 3));
        else if (kind == 1) a = 32'h400 + 32'($urandom_range(0, 1000) * 4);
        run_model(s, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
